// File: rtl/switch_conditioner.sv
// Player switch conditioner: 2-flop sync, per-bit tick-based debounce, press/release pulses.
// Optional auto-repeat pulses are built when SWITCH_AUTOREPEAT_EN is defined.
module switch_conditioner #(
    parameter int NUM_PLAYERS    = 2,
    parameter int SW_WIDTH       = 8,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 30,
    parameter int REPEAT_RATE    = 6
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tick,
    input  logic [NUM_PLAYERS*SW_WIDTH-1:0] switches_in,
    output logic [NUM_PLAYERS*SW_WIDTH-1:0] switches_out,
    output logic [NUM_PLAYERS*SW_WIDTH-1:0] pressed,
    output logic [NUM_PLAYERS*SW_WIDTH-1:0] released,
    output logic [NUM_PLAYERS*SW_WIDTH-1:0] repeat_out,
    output logic [NUM_PLAYERS-1:0]          any_pressed
);

    localparam int N   = NUM_PLAYERS * SW_WIDTH;
    localparam int DCW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DCW-1:0] DLAST = DCW'(DEBOUNCE_TICKS - 1);

    logic [N-1:0]           meta_r;
    logic [N-1:0]           sync_r;
    logic [N-1:0]           pressed_nxt_s;
    logic [NUM_PLAYERS-1:0] any_nxt_s;
    logic [NUM_PLAYERS-1:0] any_r;

    // Two-flop synchroniser, clocked every cycle independent of tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= {N{1'b0}};
            sync_r <= {N{1'b0}};
        end else begin
            meta_r <= switches_in;
            sync_r <= meta_r;
        end
    end

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            logic           stable_r;
            logic           stable_nxt_s;
            logic [DCW-1:0] dcnt_r;
            logic [DCW-1:0] dcnt_nxt_s;
            logic           accept_s;
            logic           pressed_r;
            logic           released_r;

            // Debounce: count consecutive disagreeing ticks, any agreeing tick restarts.
            always_comb begin
                stable_nxt_s = stable_r;
                dcnt_nxt_s   = dcnt_r;
                accept_s     = 1'b0;
                if (tick) begin
                    if (sync_r[i] == stable_r) begin
                        dcnt_nxt_s = {DCW{1'b0}};
                    end else if (dcnt_r == DLAST) begin
                        stable_nxt_s = sync_r[i];
                        dcnt_nxt_s   = {DCW{1'b0}};
                        accept_s     = 1'b1;
                    end else begin
                        dcnt_nxt_s = dcnt_r + DCW'(1'b1);
                    end
                end else begin
                    dcnt_nxt_s = dcnt_r;
                end
            end

            assign pressed_nxt_s[i] = accept_s & sync_r[i];

            // Debounce state and edge pulses, all updated on the accepting edge.
            always_ff @(posedge clk) begin
                if (reset) begin
                    stable_r   <= 1'b0;
                    dcnt_r     <= {DCW{1'b0}};
                    pressed_r  <= 1'b0;
                    released_r <= 1'b0;
                end else begin
                    stable_r   <= stable_nxt_s;
                    dcnt_r     <= dcnt_nxt_s;
                    pressed_r  <= accept_s & sync_r[i];
                    released_r <= accept_s & ~sync_r[i];
                end
            end

            assign switches_out[i] = stable_r;
            assign pressed[i]      = pressed_r;
            assign released[i]     = released_r;

`ifdef SWITCH_AUTOREPEAT_EN
            localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int RCW  = $clog2(RMAX + 1);
            logic [RCW-1:0] rcnt_r;
            logic [RCW-1:0] rcnt_nxt_s;
            logic           repeat_nxt_s;
            logic           repeat_r;

            // Repeat countdown; the accepting tick (press or release) overrides the countdown.
            always_comb begin
                rcnt_nxt_s   = rcnt_r;
                repeat_nxt_s = 1'b0;
                if (accept_s && sync_r[i]) begin
                    rcnt_nxt_s = RCW'(REPEAT_DELAY - 1);
                end else if (accept_s || !stable_r) begin
                    rcnt_nxt_s = {RCW{1'b0}};
                end else if (tick) begin
                    if (rcnt_r == {RCW{1'b0}}) begin
                        repeat_nxt_s = 1'b1;
                        rcnt_nxt_s   = RCW'(REPEAT_RATE - 1);
                    end else begin
                        rcnt_nxt_s = rcnt_r - RCW'(1'b1);
                    end
                end else begin
                    rcnt_nxt_s = rcnt_r;
                end
            end

            // Repeat counter and pulse register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rcnt_r   <= {RCW{1'b0}};
                    repeat_r <= 1'b0;
                end else begin
                    rcnt_r   <= rcnt_nxt_s;
                    repeat_r <= repeat_nxt_s;
                end
            end

            assign repeat_out[i] = repeat_r;
`else
            assign repeat_out[i] = 1'b0;
`endif
        end
    endgenerate

    // Per-player OR of the press pulses about to be registered.
    always_comb begin
        any_nxt_s = {NUM_PLAYERS{1'b0}};
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            any_nxt_s[p] = |pressed_nxt_s[p*SW_WIDTH +: SW_WIDTH];
        end
    end

    // Registered so any_pressed lines up with pressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_r <= {NUM_PLAYERS{1'b0}};
        end else begin
            any_r <= any_nxt_s;
        end
    end

    assign any_pressed = any_r;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed self-checking bench for switch_conditioner (default parameters).
// Repeat expectations follow SWITCH_AUTOREPEAT_EN when it is defined for the build.
module tb_switch_conditioner;

`ifdef SWITCH_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [15:0] sw_in;
    logic [15:0] sw_out;
    logic [15:0] pressed;
    logic [15:0] released;
    logic [15:0] repeat_out;
    logic [1:0]  any_pressed;

    int total  = 0;
    int passed = 0;

    switch_conditioner dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .switches_in  (sw_in),
        .switches_out (sw_out),
        .pressed      (pressed),
        .released     (released),
        .repeat_out   (repeat_out),
        .any_pressed  (any_pressed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 9 idle clocks then one tick clock: ticks every 10 clk, outputs sampled 1 ns after the tick edge.
    task automatic do_tick();
        repeat (9) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        sw_in = 16'hFFFF;
        repeat (4) step();
        check("reset_out", {16'h0, sw_out}, 32'h0);
        check("reset_pressed", {16'h0, pressed}, 32'h0);
        check("reset_any", {30'h0, any_pressed}, 32'h0);
        check("reset_repeat", {16'h0, repeat_out}, 32'h0);
        reset = 1'b0;

        // All switches held through reset: accepted on the 4th tick.
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            check("all_wait_out", {16'h0, sw_out}, 32'h0);
            check("all_wait_pressed", {16'h0, pressed}, 32'h0);
        end
        do_tick();
        check("all_out", {16'h0, sw_out}, 32'h0000FFFF);
        check("all_pressed", {16'h0, pressed}, 32'h0000FFFF);
        check("all_any", {30'h0, any_pressed}, 32'h3);
        step();
        check("all_pressed_clear", {16'h0, pressed}, 32'h0);
        check("all_any_clear", {30'h0, any_pressed}, 32'h0);

        // Release everything.
        sw_in = 16'h0000;
        repeat (3) do_tick();
        check("rel_all_wait", {16'h0, sw_out}, 32'h0000FFFF);
        do_tick();
        check("rel_all_out", {16'h0, sw_out}, 32'h0);
        check("rel_all_released", {16'h0, released}, 32'h0000FFFF);
        check("rel_all_any", {30'h0, any_pressed}, 32'h0);
        step();
        check("rel_all_released_clear", {16'h0, released}, 32'h0);

        // Glitch: fire high 3 ticks, low 1, high 4.
        sw_in = 16'h0010;
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            check("glitch_hold", {16'h0, sw_out}, 32'h0);
            check("glitch_no_press", {16'h0, pressed}, 32'h0);
        end
        sw_in = 16'h0000;
        do_tick();
        check("glitch_low", {16'h0, sw_out}, 32'h0);
        sw_in = 16'h0010;
        for (int k = 5; k <= 7; k++) begin
            do_tick();
            check("glitch_rerun", {16'h0, sw_out}, 32'h0);
        end
        do_tick();
        check("fire_out", {16'h0, sw_out}, 32'h00000010);
        check("fire_pressed", {16'h0, pressed}, 32'h00000010);
        check("fire_any", {30'h0, any_pressed}, 32'h1);

        // p2 bit 0 pressed, then released.
        sw_in = 16'h0110;
        repeat (4) do_tick();
        check("p2_pressed", {16'h0, pressed}, 32'h00000100);
        check("p2_any", {30'h0, any_pressed}, 32'h2);
        sw_in = 16'h0010;
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            check("p2_rel_wait", {16'h0, sw_out}, 32'h00000110);
            check("p2_rel_none", {16'h0, released}, 32'h0);
        end
        do_tick();
        check("p2_released", {16'h0, released}, 32'h00000100);
        check("p2_rel_out", {16'h0, sw_out}, 32'h00000010);
        check("p2_rel_any", {30'h0, any_pressed}, 32'h0);
        step();
        check("p2_released_clear", {16'h0, released}, 32'h0);

        // Tick held high 4 consecutive clocks after the change synchronised.
        sw_in = 16'h0011;
        repeat (3) step();
        tick = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("cont_wait", {16'h0, sw_out}, 32'h00000010);
        end
        step();
        check("cont_out", {16'h0, sw_out}, 32'h00000011);
        check("cont_pressed", {16'h0, pressed}, 32'h00000001);
        step();
        check("cont_pressed_clear", {16'h0, pressed}, 32'h0);
        tick = 1'b0;

        // Reset on the tick that would complete the debounce.
        sw_in = 16'h0013;
        repeat (3) do_tick();
        check("rst_pre", {16'h0, sw_out}, 32'h00000011);
        repeat (9) step();
        reset = 1'b1;
        tick  = 1'b1;
        step();
        check("rst_tick_out", {16'h0, sw_out}, 32'h0);
        check("rst_tick_pressed", {16'h0, pressed}, 32'h0);
        check("rst_tick_any", {30'h0, any_pressed}, 32'h0);
        reset = 1'b0;
        tick  = 1'b0;
        step();
        check("rst_next_pressed", {16'h0, pressed}, 32'h0);
        check("rst_next_out", {16'h0, sw_out}, 32'h0);

        // Held switches re-debounce after reset and press afresh (tick 0 for repeat).
        repeat (3) do_tick();
        check("repress_wait", {16'h0, sw_out}, 32'h0);
        do_tick();
        check("repress_out", {16'h0, sw_out}, 32'h00000013);
        check("repress_pressed", {16'h0, pressed}, 32'h00000013);
        check("repress_any", {30'h0, any_pressed}, 32'h1);

        // Auto-repeat on ticks 30, 36, 42 after the press (none without the macro).
        for (int k = 1; k <= 42; k++) begin
            do_tick();
            check($sformatf("repeat_t%0d", k), {16'h0, repeat_out},
                  (AR && (k == 30 || k == 36 || k == 42)) ? 32'h00000013 : 32'h0);
            if (k == 30) begin
                step();
                check("repeat_one_clk", {16'h0, repeat_out}, 32'h0);
            end
        end

        // Release: no repeat on the release edge or afterwards.
        sw_in = 16'h0000;
        for (int k = 43; k <= 46; k++) begin
            do_tick();
            check($sformatf("rel_repeat_t%0d", k), {16'h0, repeat_out}, 32'h0);
        end
        check("final_released", {16'h0, released}, 32'h00000013);
        check("final_out", {16'h0, sw_out}, 32'h0);
        for (int k = 47; k <= 52; k++) begin
            do_tick();
            check("idle_repeat", {16'h0, repeat_out}, 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
